multi_cycle_controller: RTL
===========================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 Parameter ST_W, default 4: width of the state output; values below 4 are not supported.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 OpCode  in  6  instruction[31:26] from the instruction register.
REQ-005 Funct  in  6  instruction[5:0] from the instruction register.
REQ-006 IRQ  in  1  external interrupt request, level.
REQ-007 KernelMode  in  1  PC[31]; when 1, IRQ is masked.
REQ-008 MemReady  in  1  memory completes the current access this cycle.
REQ-009 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuOp  out  1 each  datapath strobes and selects.
REQ-010 RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp  out  2 each  mux selects and ALU class.
REQ-011 PCSource  out  3  next-PC select: 000 ALU result, 001 ALUOut, 010 jump target, 011 rs, 100 IRQ vector, 101 exception vector.
REQ-012 State  out  ST_W  current state code, for debug.

Function
REQ-013 The block SHALL be an FSM with these states: FETCH=0, DECODE=1, EXR=2, RWB=3, EXI=4, IWB=5, ADDR=6, MRD=7, MWR=8, LWB=9, BR=10, JMP=11, JR=12, EXC=13.
REQ-014 Any output not listed for a state SHALL be 0 in that state, except ExtOp=1.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=00 (PC), ALUSrcB=01 (4), ALUOp=00, PCSource=000, and IRWrite=PCWrite=MemReady. Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
REQ-016 The IRQ is taken only in the first cycle of FETCH, and only if IRQ=1 and KernelMode=0. In that cycle MemRead=0, PCWrite=0 and IRWrite=0, and the next state is EXC with cause=IRQ.
REQ-017 Once a fetch has been issued, IRQ SHALL be ignored until the next first cycle of FETCH.
REQ-018 DECODE: ALUSrcA=00, ALUSrcB=11 (sign-extended imm<<2), ALUOp=00, producing the branch target in ALUOut.
REQ-019 DECODE next state by instruction:
  - undefined → EXC (cause=UNDEF)
  - R-type ALU/shift → EXR
  - jr/jalr → JR
  - j/jal → JMP
  - beq, bne, blez, bgtz, bltz (01) → BR
  - lw/sw → ADDR
  - other I-type → EXI
REQ-020 Undefined SHALL mean any opcode other than: 00, 01, 02, 03, 04–07, 08–0D, 0F, 23, 2B. With opcode 00, it also means any funct other than: 00, 02, 03, 08, 09, 20–27, 2A, 2B.
REQ-021 EXR: ALUSrcB=00 (rt) and ALUOp=10. ALUSrcA=01 (shamt) for funct 00/02/03, else 10 (rs). Next state RWB.
REQ-022 RWB: RegWrite=1, RegDst=01, MemToReg=00. Next state FETCH.
REQ-023 EXI: ALUSrcA=10, ALUSrcB=10 (imm), ALUOp=11, LuOp=(OpCode==0F). ExtOp=0 for 09, 0B, 0C, 0D, else 1. Next state IWB.
REQ-024 IWB: RegWrite=1, RegDst=00, MemToReg=00. Next state FETCH.
REQ-025 ADDR: ALUSrcA=10, ALUSrcB=10, ALUOp=00, ExtOp=1. Next state MRD for lw, MWR for sw.
REQ-026 MRD: MemRead=1, IorD=1. Stay while MemReady=0, then go to LWB.
REQ-027 MWR: MemWrite=1, IorD=1. Stay while MemReady=0, then go to FETCH.
REQ-028 LWB: RegWrite=1, RegDst=00, MemToReg=01. Next state FETCH.
REQ-029 BR: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=001. Next state FETCH.
REQ-030 JMP: PCWrite=1, PCSource=010. For jal also RegWrite=1, RegDst=10 ($31), MemToReg=10 (PC). Next state FETCH.
REQ-031 JR: PCWrite=1, PCSource=011. For jalr also RegWrite=1, RegDst=01, MemToReg=10. Next state FETCH.
REQ-032 EXC: RegWrite=1, RegDst=11 ($26), MemToReg=10, PCWrite=1. PCSource=100 if cause=IRQ, else 101. Next state FETCH.
REQ-033 A 1-bit cause register SHALL be written only on entry to EXC.
REQ-034 Every instruction SHALL take this many cycles, with MemReady=1 immediately: R/I-type 4, lw 5, sw 4, branch 3, jump 3, exception 3; each extra MemReady=0 cycle adds 1.

Reset
REQ-035 While reset=1 at a clock edge, the next state SHALL be FETCH, the first-cycle flag SHALL be 1, and cause SHALL be 0, regardless of MemReady or IRQ.
REQ-036 Reset SHALL abort any in-progress access.
REQ-037 After reset, the outputs SHALL be the FETCH values with State=0.

Verification
REQ-038 add (OpCode 00, Funct 20), MemReady=1 → states 0,1,2,3,0; RegWrite=1 only in state 3 with RegDst=01.
REQ-039 lw (23) with MemReady low for 2 cycles in MRD → states 0,1,6,7,7,7,9,0; MemToReg=01 in state 9.
REQ-040 IRQ=1, KernelMode=0 on the first FETCH cycle → MemRead=0, then EXC with PCSource=100, RegDst=11; with KernelMode=1, a normal fetch.
REQ-041 IRQ rising during the FETCH wait (MemReady=0 for 3 cycles) → the fetch completes to DECODE; IRQ is taken at the next FETCH.
REQ-042 OpCode 10 (undefined) → states 0,1,13,0 with PCSource=101.
REQ-043 Reset asserted in MWR with MemReady=0 → the next cycle is State=0, MemWrite=0, MemRead=1.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and selects, and traps on IRQ (first fetch cycle) or undefined opcodes.
module multi_cycle_controller #(
  parameter int unsigned ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      OpCode,
  input  logic [5:0]      Funct,
  input  logic            IRQ,
  input  logic            KernelMode,
  input  logic            MemReady,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            ExtOp,
  output logic            LuOp,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemToReg,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [2:0]      PCSource,
  output logic [ST_W-1:0] State
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  EXR = 4'd2,  RWB = 4'd3,
    EXI    = 4'd4,  IWB    = 4'd5,  ADDR = 4'd6, MRD = 4'd7,
    MWR    = 4'd8,  LWB    = 4'd9,  BR = 4'd10,  JMP = 4'd11,
    JR     = 4'd12, EXC    = 4'd13
  } state_t;

  localparam logic       CAUSE_UNDEF = 1'b0;
  localparam logic       CAUSE_IRQ   = 1'b1;

  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_SHAMT = 2'b01, SRCA_RS = 2'b10;
  localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_BRANCH = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_RTYPE = 2'b10, ALU_ITYPE = 2'b11;
  localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_RA = 2'b10, DST_K0 = 2'b11;
  localparam logic [1:0] WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10;
  localparam logic [2:0] PCS_ALU = 3'b000, PCS_ALUOUT = 3'b001, PCS_JUMP = 3'b010,
                         PCS_RS = 3'b011, PCS_IRQ = 3'b100, PCS_EXC = 3'b101;

  state_t state, nextState;
  logic   firstCycle;
  logic   cause;
  logic   takeIrq;

  // Instruction class dispatch out of DECODE; anything unrecognised traps.
  function automatic state_t decodeTarget(input logic [5:0] op, input logic [5:0] fn);
    state_t t;
    t = EXC;
    case (op)
      6'h00: begin
        if (fn == 6'h08 || fn == 6'h09) t = JR;
        else if (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B}) t = EXR;
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07:                 t = BR;
      6'h02, 6'h03:                                       t = JMP;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F:   t = EXI;
      6'h23, 6'h2B:                                       t = ADDR;
      default:                                            t = EXC;
    endcase
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      firstCycle <= 1'b1;
      cause      <= CAUSE_UNDEF;
    end else begin
      state      <= nextState;
      firstCycle <= (nextState == FETCH) && (state != FETCH);
      if (nextState == EXC && state != EXC) cause <= takeIrq ? CAUSE_IRQ : CAUSE_UNDEF;
    end
  end

  always_comb begin
    nextState   = state;
    takeIrq     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b1;
    LuOp        = 1'b0;
    RegDst      = DST_RT;
    MemToReg    = WB_ALU;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALU_ADD;
    PCSource    = PCS_ALU;
    case (state)
      FETCH: begin
        ALUSrcB = SRCB_FOUR;
        // Interrupts are only accepted before the fetch is issued.
        if (firstCycle && IRQ && !KernelMode) begin
          takeIrq   = 1'b1;
          nextState = EXC;
        end else begin
          MemRead = 1'b1;
          IRWrite = MemReady;
          PCWrite = MemReady;
          if (MemReady) nextState = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB   = SRCB_BRANCH;
        nextState = decodeTarget(OpCode, Funct);
      end
      EXR: begin
        ALUOp     = ALU_RTYPE;
        ALUSrcA   = (Funct inside {6'h00, 6'h02, 6'h03}) ? SRCA_SHAMT : SRCA_RS;
        nextState = RWB;
      end
      RWB: begin
        RegWrite  = 1'b1;
        RegDst    = DST_RD;
        nextState = FETCH;
      end
      EXI: begin
        ALUSrcA   = SRCA_RS;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALU_ITYPE;
        LuOp      = (OpCode == 6'h0F);
        ExtOp     = !(OpCode inside {6'h09, 6'h0B, 6'h0C, 6'h0D});
        nextState = IWB;
      end
      IWB: begin
        RegWrite  = 1'b1;
        nextState = FETCH;
      end
      ADDR: begin
        ALUSrcA   = SRCA_RS;
        ALUSrcB   = SRCB_IMM;
        nextState = (OpCode == 6'h23) ? MRD : MWR;
      end
      MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) nextState = LWB;
      end
      MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) nextState = FETCH;
      end
      LWB: begin
        RegWrite  = 1'b1;
        MemToReg  = WB_MEM;
        nextState = FETCH;
      end
      BR: begin
        ALUSrcA     = SRCA_RS;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        nextState   = FETCH;
      end
      JMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
        if (OpCode == 6'h03) begin
          RegWrite = 1'b1;
          RegDst   = DST_RA;
          MemToReg = WB_PC;
        end
        nextState = FETCH;
      end
      JR: begin
        PCWrite  = 1'b1;
        PCSource = PCS_RS;
        if (Funct == 6'h09) begin
          RegWrite = 1'b1;
          RegDst   = DST_RD;
          MemToReg = WB_PC;
        end
        nextState = FETCH;
      end
      EXC: begin
        RegWrite  = 1'b1;
        RegDst    = DST_K0;
        MemToReg  = WB_PC;
        PCWrite   = 1'b1;
        PCSource  = (cause == CAUSE_IRQ) ? PCS_IRQ : PCS_EXC;
        nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  assign State = ST_W'(state);

endmodule
